// File: rtl/shift_reg_ctrl_pkg.sv
// Shared types and constants for the shift_reg_ctrl frame sequencer.
package shift_reg_ctrl_pkg;

  // Gap counter width; it holds GAP_CYCLES-1 for GAP_CYCLES in 0..15.
  localparam int GAP_W = 4;

  // Controller states. PARITY is reachable only when SHIFT_REG_CTRL_PARITY_EN is defined.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SHIFT  = 3'd2,
    PARITY = 3'd3,
    GAP    = 3'd4,
    CLEAR  = 3'd5
  } state_t;

  // Width of the bit counter that counts W-1 down to 0.
  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/shift_reg_ctrl_cnt.sv
// Loadable down-counter with a zero flag; holds at zero rather than wrapping.
module shift_reg_ctrl_cnt #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  // Load has priority over decrement; a decrement at zero is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/shift_reg_ctrl.sv
// Frame sequencer for one shift_reg: accepts words on valid/ready, drives load and
// enable cycles, and presents the serial stream with frame markers. Services clear
// requests between frames. Optional feature macro: SHIFT_REG_CTRL_PARITY_EN appends
// an even-parity bit to every frame.
module shift_reg_ctrl
  import shift_reg_ctrl_pkg::*;
#(
  parameter int    SHIFT_WIDTH     = 8,
  parameter string SHIFT_DIRECTION = "LEFT",
  parameter int    GAP_CYCLES      = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SHIFT_WIDTH-1:0] in_data,
  input  logic                   clear_req,
  output logic                   sr_load,
  output logic                   sr_enable,
  output logic                   sr_sclr,
  output logic                   sr_sset,
  output logic                   sr_shiftin,
  output logic [SHIFT_WIDTH-1:0] sr_data,
  input  logic                   sr_shiftout,
  output logic                   ser_out,
  output logic                   ser_valid,
  output logic                   frame_start,
  output logic                   frame_end,
  output logic                   busy
);

  localparam int CNT_W = cnt_width(SHIFT_WIDTH);
  localparam logic [CNT_W-1:0] BIT_LOAD = CNT_W'(SHIFT_WIDTH - 1);
  localparam logic [CNT_W-1:0] BIT_ONE  = CNT_W'(1);
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

`ifdef SHIFT_REG_CTRL_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  // Parameter sanity checks at elaboration; the direction only documents the attached shift_reg.
  if (SHIFT_WIDTH < 2) begin : g_bad_width
    $error("shift_reg_ctrl: SHIFT_WIDTH must be >= 2");
  end
  if ((GAP_CYCLES < 0) || (GAP_CYCLES > 15)) begin : g_bad_gap
    $error("shift_reg_ctrl: GAP_CYCLES must be in 0..15");
  end
  if ((SHIFT_DIRECTION != "LEFT") && (SHIFT_DIRECTION != "RIGHT")) begin : g_bad_dir
    $error("shift_reg_ctrl: SHIFT_DIRECTION must be LEFT or RIGHT");
  end

  state_t             state;
  logic               clear_pend;
  logic               clear_now;
  logic               bit_load;
  logic               bit_dec;
  logic [CNT_W-1:0]   bit_count;
  logic               bit_zero;
  logic               gap_load;
  logic               gap_dec;
  logic [GAP_W-1:0]   gap_count_unused;
  logic               gap_zero;

`ifdef SHIFT_REG_CTRL_PARITY_EN
  logic               par;
`endif

  // A request seen this cycle counts the same as one already pending.
  assign clear_now = clear_pend | clear_req;

  // Bit counter starts at W-1 for the first SHIFT cycle and steps down once per shifted bit.
  assign bit_load = (state == LOAD);
  assign bit_dec  = (state == SHIFT);

  // Gap counter is reloaded whenever we are outside GAP so it is ready on entry.
  assign gap_load = (state != GAP);
  assign gap_dec  = (state == GAP);

  shift_reg_ctrl_cnt #(.WIDTH(CNT_W)) u_bit_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (bit_load),
    .load_value (BIT_LOAD),
    .dec        (bit_dec),
    .count      (bit_count),
    .zero       (bit_zero)
  );

  shift_reg_ctrl_cnt #(.WIDTH(GAP_W)) u_gap_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (gap_load),
    .load_value (GAP_LOAD),
    .dec        (gap_dec),
    .count      (gap_count_unused),
    .zero       (gap_zero)
  );

  assign sr_sset    = 1'b0;
  assign sr_shiftin = 1'b0;

`ifdef SHIFT_REG_CTRL_PARITY_EN
  assign ser_out = ser_valid & ((state == PARITY) ? par : sr_shiftout);
`else
  assign ser_out = ser_valid & sr_shiftout;
`endif

  // Sequencer: every output register is set for the state being entered, so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      clear_pend  <= 1'b0;
      in_ready    <= 1'b0;
      sr_load     <= 1'b0;
      sr_enable   <= 1'b0;
      sr_sclr     <= 1'b0;
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      busy        <= 1'b0;
      sr_data     <= '0;
`ifdef SHIFT_REG_CTRL_PARITY_EN
      par         <= 1'b0;
`endif
    end else begin
      sr_load     <= 1'b0;
      sr_enable   <= 1'b0;
      sr_sclr     <= 1'b0;
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      in_ready    <= 1'b0;
      busy        <= 1'b1;
      clear_pend  <= clear_pend | clear_req;

      case (state)
        IDLE: begin
          if (clear_now) begin
            state      <= CLEAR;
            sr_sclr    <= 1'b1;
            sr_enable  <= 1'b1;
            clear_pend <= 1'b0;
          end else if (in_valid && in_ready) begin
            state     <= LOAD;
            sr_data   <= in_data;
`ifdef SHIFT_REG_CTRL_PARITY_EN
            par       <= ^in_data;
`endif
            sr_load   <= 1'b1;
            sr_enable <= 1'b1;
          end else begin
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end

        LOAD: begin
          state       <= SHIFT;
          sr_enable   <= 1'b1;
          ser_valid   <= 1'b1;
          frame_start <= 1'b1;
        end

        SHIFT: begin
          if (!bit_zero) begin
            sr_enable <= 1'b1;
            ser_valid <= 1'b1;
            frame_end <= (bit_count == BIT_ONE) && !PAR_EN;
          end else if (PAR_EN) begin
            state     <= PARITY;
            ser_valid <= 1'b1;
            frame_end <= 1'b1;
          end else if (GAP_CYCLES != 0) begin
            state <= GAP;
          end else if (clear_now) begin
            state      <= CLEAR;
            sr_sclr    <= 1'b1;
            sr_enable  <= 1'b1;
            clear_pend <= 1'b0;
          end else begin
            state    <= IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end

`ifdef SHIFT_REG_CTRL_PARITY_EN
        PARITY: begin
          if (GAP_CYCLES != 0) begin
            state <= GAP;
          end else if (clear_now) begin
            state      <= CLEAR;
            sr_sclr    <= 1'b1;
            sr_enable  <= 1'b1;
            clear_pend <= 1'b0;
          end else begin
            state    <= IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end
`endif

        GAP: begin
          if (gap_zero) begin
            if (clear_now) begin
              state      <= CLEAR;
              sr_sclr    <= 1'b1;
              sr_enable  <= 1'b1;
              clear_pend <= 1'b0;
            end else begin
              state    <= IDLE;
              in_ready <= 1'b1;
              busy     <= 1'b0;
            end
          end
        end

        CLEAR: begin
          state    <= IDLE;
          in_ready <= !clear_req;
          busy     <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
